// File: rtl/bk_adder_pipe_if.sv
// Operand/result handshake bundle for bk_adder_pipe.
//   in_valid/in_ready : operand beat handshake (a, b, cin, sub)
//   out_valid/out_ready : result beat handshake (sum, cout, ovf)
// The master modport is the producer/consumer side; the slave modport is the adder.
interface bk_adder_pipe_if #(
  parameter int unsigned WIDTH = 12
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung add/subtract with carry-in, carry-out and signed overflow.
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   bus        : slave side of bk_adder_pipe_if (operands in, result out)
// The prefix tree has 2*ceil(log2(WIDTH))-1 levels (up-sweep then down-sweep).
// PIPE_STAGES registers are spread across the level boundaries; the last one is
// the output register. All stages advance together on adv = ~out_valid | out_ready.
module bk_adder_pipe #(
  parameter int unsigned WIDTH       = 12,
  parameter int unsigned PIPE_STAGES = 2
) (
  input logic          clk,
  input logic          rst_n,
  bk_adder_pipe_if.slave bus
);

  localparam int unsigned K  = $clog2(WIDTH);
  localparam int unsigned LV = 2 * K - 1;

  // True when a pipeline register sits right after prefix level lvl.
  // Register r (r < PIPE_STAGES-1) follows level floor((r+1)*LV/PIPE_STAGES).
  function automatic bit reg_after(input int unsigned lvl);
    bit hit;
    hit = 1'b0;
    for (int unsigned r = 0; r + 1 < PIPE_STAGES; r++) begin
      if ((r + 1) * LV / PIPE_STAGES == lvl) hit = 1'b1;
    end
    return hit;
  endfunction

  logic adv;

  assign adv          = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar lv = 0; lv <= LV; lv++) begin : g_lvl
    logic [WIDTH-1:0] g_c;
    logic [WIDTH-1:0] p_c;
    logic [WIDTH-1:0] p0_c;
    logic             ci_c;
    logic             v_c;

    if (lv == 0) begin : g_gp
      // Level 0: bitwise generate/propagate; effective carry-in folded into bit 0.
      logic [WIDTH-1:0] b_eff;
      logic             ci_eff;

      assign b_eff  = bus.sub ? ~bus.b : bus.b;
      assign ci_eff = bus.sub | bus.cin;
      assign p0_c   = bus.a ^ b_eff;
      assign p_c    = p0_c;
      assign g_c    = (bus.a & b_eff) | {{(WIDTH-1){1'b0}}, p0_c[0] & ci_eff};
      assign ci_c   = ci_eff;
      assign v_c    = bus.in_valid & adv;
    end else begin : g_pre
      // Levels 1..K are the up-sweep, K+1..2K-1 the down-sweep.
      localparam bit          UP   = (lv <= K);
      localparam int unsigned SH   = UP ? lv - 1 : 2 * K - 1 - lv;
      localparam int unsigned DIST = 1 << SH;

      assign p0_c = g_lvl[lv-1].g_bnd.p0_s;
      assign ci_c = g_lvl[lv-1].g_bnd.ci_s;
      assign v_c  = g_lvl[lv-1].g_bnd.v_s;

      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam bit NODE = UP ? (((i + 1) % (2 * DIST)) == 0)
                                 : ((((i + 1) % (2 * DIST)) == DIST) && (i + 1 > DIST));
        if (NODE) begin : g_op
          assign g_c[i] = g_lvl[lv-1].g_bnd.g_s[i]
                        | (g_lvl[lv-1].g_bnd.p_s[i] & g_lvl[lv-1].g_bnd.g_s[i-DIST]);
          assign p_c[i] = g_lvl[lv-1].g_bnd.p_s[i] & g_lvl[lv-1].g_bnd.p_s[i-DIST];
        end else begin : g_pass
          assign g_c[i] = g_lvl[lv-1].g_bnd.g_s[i];
          assign p_c[i] = g_lvl[lv-1].g_bnd.p_s[i];
        end
      end
    end

    if (lv < LV) begin : g_bnd
      logic [WIDTH-1:0] g_s;
      logic [WIDTH-1:0] p_s;
      logic [WIDTH-1:0] p0_s;
      logic             ci_s;
      logic             v_s;

      if (reg_after(lv)) begin : g_reg
        // Stage valid: cleared by reset, shifts with the global enable.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            v_s <= 1'b0;
          end else if (adv) begin
            v_s <= v_c;
          end
        end

        // Stage data: only captured for real beats, so bubbles never load X.
        always_ff @(posedge clk) begin
          if (adv && v_c) begin
            g_s  <= g_c;
            p_s  <= p_c;
            p0_s <= p0_c;
            ci_s <= ci_c;
          end
        end
      end else begin : g_wire
        assign g_s  = g_c;
        assign p_s  = p_c;
        assign p0_s = p0_c;
        assign ci_s = ci_c;
        assign v_s  = v_c;
      end
    end
  end

  // Final level holds every prefix carry; c_in[i] is the carry into bit i.
  logic [WIDTH-1:0] c_in;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;
  logic             unused_p;

  assign c_in     = {g_lvl[LV].g_c[WIDTH-2:0], g_lvl[LV].ci_c};
  assign cout_c   = g_lvl[LV].g_c[WIDTH-1];
  assign sum_c    = g_lvl[LV].p0_c ^ c_in;
  assign ovf_c    = c_in[WIDTH-1] ^ cout_c;
  // Group propagate of the last level has no consumer.
  assign unused_p = ^g_lvl[LV].p_c;

  // Output register; result is held while out_valid=1 and out_ready=0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.sum       <= '0;
      bus.cout      <= 1'b0;
      bus.ovf       <= 1'b0;
    end else if (adv) begin
      bus.out_valid <= g_lvl[LV].v_c;
      if (g_lvl[LV].v_c) begin
        bus.sum  <= sum_c;
        bus.cout <= cout_c;
        bus.ovf  <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Self-checking bench for bk_adder_pipe: directed vectors, random stream, stall,
// reset flush on WIDTH=12/PIPE_STAGES=2, plus a width/depth sweep of instances.
module tb_bk_adder_pipe;

  localparam int unsigned W = 12;
  localparam int unsigned S = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bk_adder_pipe_if #(.WIDTH(W)) bif ();

  bk_adder_pipe #(.WIDTH(W), .PIPE_STAGES(S)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif.slave)
  );

  // Reference: returns {ovf, cout, sum[31:0]} for a w-bit operation.
  function automatic logic [33:0] ref_add(input int unsigned w, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin,
                                          input logic sub);
    logic [63:0] mask, bb, t;
    logic [31:0] s;
    logic        co, sa, sb, ss;
    mask = (64'd1 << w) - 64'd1;
    bb   = {32'd0, (sub ? ~b : b)} & mask;
    t    = ({32'd0, a} & mask) + bb + 64'(sub | cin);
    s    = 32'(t & mask);
    co   = t[w];
    sa   = a[w-1];
    sb   = bb[w-1];
    ss   = s[w-1];
    return {(sa == sb) && (ss != sa), co, s};
  endfunction

  function automatic logic [33:0] dut_res();
    return {bif.ovf, bif.cout, 20'd0, bif.sum};
  endfunction

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic s);
    bif.in_valid = v;
    bif.a        = a[11:0];
    bif.b        = b[11:0];
    bif.cin      = c;
    bif.sub      = s;
  endtask

  // Directed vectors with hand-computed results.
  logic [11:0] da  [9] = '{12'hFFF, 12'h7FF, 12'h005, 12'h123, 12'h800, 12'h000, 12'h555, 12'h800, 12'h000};
  logic [11:0] db  [9] = '{12'h001, 12'h001, 12'h007, 12'h023, 12'h800, 12'h000, 12'hAAA, 12'h001, 12'h000};
  logic        dc  [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        ds  [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [11:0] es  [9] = '{12'h000, 12'h800, 12'hFFE, 12'h100, 12'h001, 12'h001, 12'h000, 12'h7FF, 12'h000};
  logic        eco [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic        eov [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  logic [33:0] rq [64];

  // Shared stimulus for the sweep instances.
  logic        sw_valid;
  logic [31:0] sw_a, sw_b;
  logic        sw_cin, sw_sub;
  logic        sweep_chk;

  for (genvar wi = 0; wi < 4; wi++) begin : g_w
    localparam int unsigned SW = (wi == 0) ? 2 : (wi == 1) ? 12 : (wi == 2) ? 17 : 32;
    for (genvar s = 1; s <= 2 * $clog2(SW); s++) begin : g_s
      bk_adder_pipe_if #(.WIDTH(SW)) sif ();
      logic [33:0] q [$];
      int          qc [$];
      logic [33:0] exp_r, got_r;
      logic        have;
      int          lat;

      assign sif.in_valid  = sw_valid;
      assign sif.a         = sw_a[SW-1:0];
      assign sif.b         = sw_b[SW-1:0];
      assign sif.cin       = sw_cin;
      assign sif.sub       = sw_sub;
      assign sif.out_ready = 1'b1;

      bk_adder_pipe #(.WIDTH(SW), .PIPE_STAGES(s)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (sif.slave)
      );

      always @(posedge clk) begin
        if (!rst_n) begin
          q.delete();
          qc.delete();
        end else if (sif.in_valid && sif.in_ready) begin
          q.push_back(ref_add(SW, sw_a, sw_b, sw_cin, sw_sub));
          qc.push_back(cyc);
        end
        if (sweep_chk) begin
          n_chk++;
          assert (q.size() == 0) else begin
            n_fail++;
            $error("FAIL sweep_drain w=%0d s=%0d: pending %0d expected 0", SW, s, q.size());
          end
        end
      end

      always @(negedge clk) begin
        if (sif.out_valid) begin
          have = (q.size() != 0);
          if (have) begin
            exp_r = q.pop_front();
            lat   = cyc - qc.pop_front();
          end else begin
            exp_r = '0;
            lat   = -1;
          end
          got_r = {sif.ovf, sif.cout, 32'(sif.sum)};
          n_chk++;
          assert (have && got_r === exp_r && lat == s) else begin
            n_fail++;
            $error("FAIL sweep w=%0d s=%0d: got %0h lat %0d expected %0h lat %0d (queued %0d)",
                   SW, s, got_r, lat, exp_r, s, have);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] ra, rb, r;
    logic        rc, rs;

    rst_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    bif.out_ready = 1'b0;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    sweep_chk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state; in_ready must be 1 even with out_ready low.
    chk("reset_out_valid", 34'(bif.out_valid), 34'd0);
    chk("reset_result", dut_res(), 34'd0);
    chk("reset_in_ready", 34'(bif.in_ready), 34'd1);
    bif.out_ready = 1'b1;

    // Directed back-to-back vectors, two-cycle latency.
    for (int i = 0; i < 11; i++) begin
      if (i < 9) drive(1'b1, 32'(da[i]), 32'(db[i]), dc[i], ds[i]);
      else       drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      chk("dir_in_ready", 34'(bif.in_ready), 34'd1);
      if (i >= 1 && i <= 9) begin
        chk("dir_out_valid", 34'(bif.out_valid), 34'd1);
        chk("dir_result", dut_res(), {eov[i-1], eco[i-1], 20'd0, es[i-1]});
      end else begin
        chk("dir_out_idle", 34'(bif.out_valid), 34'd0);
      end
    end

    // 64 random back-to-back beats.
    for (int i = 0; i < 66; i++) begin
      if (i < 64) begin
        ra = $urandom();
        rb = $urandom();
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        drive(1'b1, ra, rb, rc, rs);
        rq[i] = ref_add(W, ra, rb, rc, rs);
      end else begin
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      end
      @(negedge clk);
      chk("rand_in_ready", 34'(bif.in_ready), 34'd1);
      if (i >= 1 && i <= 64) begin
        chk("rand_out_valid", 34'(bif.out_valid), 34'd1);
        chk("rand_result", dut_res(), rq[i-1]);
      end else begin
        chk("rand_out_idle", 34'(bif.out_valid), 34'd0);
      end
    end

    // Stall: hold X at the output for 5 cycles with Y in flight and Z waiting.
    drive(1'b1, 32'h3A5, 32'h15C, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h9C4, 32'h2B1, 1'b0, 1'b1);
    @(negedge clk);
    chk("stall_x_pre", dut_res(), {1'b0, 1'b0, 20'd0, 12'h501});
    bif.out_ready = 1'b0;
    drive(1'b1, 32'h001, 32'h002, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_out_valid", 34'(bif.out_valid), 34'd1);
      chk("stall_hold", dut_res(), {1'b0, 1'b0, 20'd0, 12'h501});
      chk("stall_in_ready", 34'(bif.in_ready), 34'd0);
    end
    bif.out_ready = 1'b1;
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("stall_y", dut_res(), {1'b1, 1'b1, 20'd0, 12'h713});
    chk("stall_y_valid", 34'(bif.out_valid), 34'd1);
    @(negedge clk);
    chk("stall_z", dut_res(), {1'b0, 1'b0, 20'd0, 12'h003});
    chk("stall_z_valid", 34'(bif.out_valid), 34'd1);
    @(negedge clk);
    chk("stall_drained", 34'(bif.out_valid), 34'd0);

    // Reset with beats in flight and a beat offered during reset.
    drive(1'b1, 32'h111, 32'h222, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h0F0, 32'h00F, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 32'h333, 32'h444, 1'b1, 1'b0);
    @(negedge clk);
    chk("flush_out_valid", 34'(bif.out_valid), 34'd0);
    chk("flush_result", dut_res(), 34'd0);
    rst_n = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_no_ghost", 34'(bif.out_valid), 34'd0);
      chk("flush_in_ready", 34'(bif.in_ready), 34'd1);
    end

    // Sweep: first 64 beats walk all WIDTH=2 operand combinations.
    for (int i = 0; i < 128; i++) begin
      sw_valid = 1'b1;
      r = $urandom();
      if (i < 64) begin
        sw_a   = {r[31:2], 2'(i)};
        r      = $urandom();
        sw_b   = {r[31:2], 2'(i >> 2)};
        sw_cin = 1'(i >> 4);
        sw_sub = 1'(i >> 5);
      end else begin
        sw_a   = r;
        sw_b   = $urandom();
        sw_cin = 1'($urandom_range(0, 1));
        sw_sub = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    sw_valid = 1'b0;
    repeat (12) @(negedge clk);
    sweep_chk = 1'b1;
    @(negedge clk);
    sweep_chk = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bk_adder_pipe.md
Name: bk_adder_pipe

Overview:
Parametrised, pipelined successor to the team's flat combinational Brent-Kung adder. It computes a WIDTH-bit add or subtract with carry-in, carry-out and signed overflow. It uses a Brent-Kung parallel-prefix carry tree split into PIPE_STAGES register stages and a valid/ready handshake on both sides. It sits in arithmetic datapaths that need full throughput at higher clock rates than the single-cycle adder closes at.

Parameters:
WIDTH, 12, operand width in bits; any value ≥2, non-power-of-2 allowed.
PIPE_STAGES, 2, number of register stages from input acceptance to output; legal range is 1 to 2*ceil(log2(WIDTH)).

Ports:
clk  in  1  single clock; all state updates on its rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
a  in  WIDTH  operand A (unsigned or two's complement)
b  in  WIDTH  operand B
cin  in  1  carry-in; ignored when sub=1
sub  in  1  0 = a+b+cin; 1 = a-b, computed as a+~b+1
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
sum  out  WIDTH  result bits
cout  out  1  carry out of the MSB; when sub=1 it is the not-borrow flag (1 means a≥b unsigned)
ovf  out  1  signed overflow; equals carry into MSB XOR cout

Behaviour:
- Generate/propagate: g_i=a_i&b'_i, p_i=a_i^b'_i, where b'=sub?~b:b. The effective carry-in is sub?1:cin and is folded in as position -1.
- Carry network is Brent-Kung: up-sweep then down-sweep, with 2*ceil(log2(WIDTH))-1 prefix levels. No Kogge-Stone or ripple substitution is allowed.
- Pipeline registers are placed between prefix levels, spread as evenly as possible; the last register is the output register. The value of each result must be bit-identical to (a + b' + cin_eff) mod 2^(WIDTH+1), independent of PIPE_STAGES.
- Stall control is a single global enable: adv = ~out_valid | out_ready. in_ready = adv, driven combinationally.
- When adv=1, every stage shifts forward one place. Stage-0 valid loads in_valid & in_ready.
- When adv=0, all stages hold their data and valids.
- Bubbles are not squeezed out during a stall.
- A beat is accepted on an edge where in_valid=1 and in_ready=1. Its result appears with out_valid=1 exactly PIPE_STAGES cycles later, provided no stall cycles intervene. Each stall cycle adds one cycle.
- Throughput is one beat per cycle while out_ready is held at 1.
- Output stability: while out_valid=1 and out_ready=0, sum, cout and ovf must not change.
- Reset, synchronous on rst_n=0:
  - All stage valids, including out_valid, go to 0.
  - sum, cout and ovf are cleared to 0.
  - in_ready reads 1 from the first cycle after reset.
  - Beats in flight are discarded with no partial output.
  - Reset takes priority over any in_valid or out_ready activity in the same cycle.
- Simultaneous accept at the input and drain at the output in one cycle is legal and keeps full throughput.
- Data paths of stages whose valid is 0 may hold garbage, but out_valid=0 must never coincide with a flag assertion being consumed.
- The block has no X-propagation dependence: outputs are deterministic after reset even if a, b or cin are X while in_valid=0.

Test Plan:
- WIDTH=12, PIPE_STAGES=2, out_ready=1; a=0xFFF, b=0x001, cin=0, sub=0 -> two cycles after accept: sum=0x000, cout=1, ovf=0.
- a=0x7FF, b=0x001, cin=0, sub=0 -> sum=0x800, cout=0, ovf=1. Then a=0x005, b=0x007, sub=1, cin=1 (ignored) -> sum=0xFFE, cout=0, ovf=0.
- 64 back-to-back random beats with out_ready=1 -> 64 results in order, one per cycle, each matching the reference model; in_ready constantly 1.
- Hold out_ready=0 for 5 cycles while a result is valid -> sum, cout and ovf stay constant, in_ready=0 throughout, no beat is lost or duplicated after release.
- Assert rst_n=0 for one cycle with 2 beats in flight -> out_valid=0 and sum=0 on the next cycle, the in-flight beats never appear, in_ready=1 afterwards.
- Sweep WIDTH ∈ {2,12,17,32} and PIPE_STAGES from 1 to max, with exhaustive operands for WIDTH=2 and random operands otherwise -> all results correct and latency equals PIPE_STAGES.
